xh_bitmap_overlay: RTL
======================

Name: xh_bitmap_overlay

Overview:
- Video-path stage that consumes the 1024 x 224-bit bitmap ROM (xh_rom). Each ROM word is one bitmap row; bit DATA_WIDTH-1 is the leftmost pixel.
- Tracks raster position from incoming sync/DE and drives the ROM address.
- Absorbs the ROM's 1-cycle read latency, then overlays the bitmap onto the pass-through RGB stream at a per-frame-latched screen position.
- Sits between the video timing/scope-trace composer and the HDMI output encoder.

Parameters:
- ADDR_WIDTH, 10, ROM address width; bitmap height limit 2**ADDR_WIDTH rows
- DATA_WIDTH, 224, ROM word width = bitmap width in pixels
- BMP_H, 128, bitmap rows actually displayed (1..2**ADDR_WIDTH)
- CW, 12, pixel coordinate width
- VS_POL, 1, active level of vs_in (1 = active-high)

Ports:
- clk  in  1  pixel clock, shared with ROM
- rst_n  in  1  asynchronous active-low reset
- vs_in  in  1  vertical sync
- hs_in  in  1  horizontal sync
- de_in  in  1  data enable (active video)
- rgb_in  in  24  input pixel {R,G,B}
- ovl_en  in  1  overlay enable, sampled at frame start
- pos_x  in  CW  bitmap left column, sampled at frame start
- pos_y  in  CW  bitmap top row, sampled at frame start
- fg_color  in  24  colour for bitmap '1' pixels
- bg_color  in  24  colour for bitmap '0' pixels (used only with the optional feature)
- rom_addr  out  ADDR_WIDTH  ROM row address
- rom_rd_data  in  DATA_WIDTH  ROM read data, valid 1 clk after rom_addr
- vs_out  out  1  vs_in delayed 3 clks
- hs_out  out  1  hs_in delayed 3 clks
- de_out  out  1  de_in delayed 3 clks
- rgb_out  out  24  composited pixel, aligned with de_out

Behaviour:
- Reset (async on rst_n low; sync release not required): all outputs 0, rom_addr 0, counters 0, latched pos/enable 0, pipeline cleared.
- Frame start = active edge of vs_in (edge per VS_POL):
  - y_cnt <= 0
  - pos_x/pos_y/ovl_en latched into frame registers; mid-frame changes are ignored until the next frame start.
- x_cnt:
  - increments on each clk with de_in=1, starting at 0 for the first DE pixel of a line
  - cleared when de_in=0
  - saturates at all-ones (no wrap)
- y_cnt: increments on each falling edge of de_in; saturates. Frame start has priority over a coincident DE falling edge.
- Stage 0 (registered at end of cycle N):
  - dx = x_cnt - pos_x_l and dy = y_cnt - pos_y_l, computed in CW+1 bits
  - hit = ovl_en_l & de_in & dx in [0, DATA_WIDTH-1] & dy in [0, BMP_H-1]
  - on hit: rom_addr <= dy[ADDR_WIDTH-1:0], else rom_addr holds its previous value
  - delay pipe stores hit, dx bit index, rgb_in, vs/hs/de
- Stage 1 (cycle N+1): rom_rd_data valid for the stage-0 address; the pipe advances.
- Stage 2 (registered, outputs at N+3 relative to input sample N):
  - bit = rom_rd_data[DATA_WIDTH-1-dx] using the stage-1 captured word
  - rgb_out = (hit & bit) ? fg_color : rgb_in_delayed
- Latency: fixed 3 clks for vs/hs/de/rgb, with no bubbles; all four are delayed identically.
- When de_out=0, rgb_out = 0.
- Clipping: bitmap portions beyond the active line/frame are simply not displayed; there is no wrap to the next line.
- Reset mid-frame: counters restart at 0, so overlay placement may be wrong until the next frame start. This is accepted. No X/hang is permitted.
- ovl_en_l=0: rgb_out equals rgb_in delayed by 3 clks, bit-exact.

Optional Feature:
- Macro XH_OVERLAY_BG_EN.
- Defined: inside the window (hit=1), pixels with bit=0 output bg_color, giving an opaque box behind the glyphs.
- Undefined: bit=0 pixels pass rgb_in through (transparent); bg_color is unused and may be left unconnected.

Test Plan:
- Pass-through: ovl_en=0, 1280x720 timing, rgb_in = 24'h123456 + x → rgb_out/vs/hs/de equal inputs delayed exactly 3 clks, bit-exact.
- Placement: ovl_en=1, pos=(100,50), ROM row0 = all ones, fg=24'hFF0000 → line 50, columns 100..323 red; column 99, column 324 and line 49 unchanged; rom_addr=0 during line 50.
- Bit order: ROM row5 = only MSB set → only pixel (100,55) is fg; row5 LSB set alone → only (323,55).
- Frame-latched position: change pos_x 100→200 at line 300 → current frame stays at x=100; next frame is at x=200.
- Clipping/saturation: pos=(1200,700), BMP_H=128 → columns 1200..1279 and lines 700..719 overlaid, nothing wraps; no overlay in the next frame's top lines.
- Reset mid-frame: assert rst_n=0 for 3 clks at line 400 → all outputs 0 immediately; after the next vs, placement is correct again. With XH_OVERLAY_BG_EN, zero bits in the window output bg_color=24'h0000FF.

Source files
------------

// File: rtl/xh_bitmap_overlay.sv
// Overlays a 1-bpp bitmap row ROM onto a pass-through RGB stream at a per-frame-latched position.
// Optional macro XH_OVERLAY_BG_EN: zero bits inside the window are painted bg_color (opaque box).
module xh_bitmap_overlay #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 224,
    parameter int BMP_H      = 128,
    parameter int CW         = 12,
    parameter bit VS_POL     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vs_in,
    input  logic                  hs_in,
    input  logic                  de_in,
    input  logic [23:0]           rgb_in,
    input  logic                  ovl_en,
    input  logic [CW-1:0]         pos_x,
    input  logic [CW-1:0]         pos_y,
    input  logic [23:0]           fg_color,
    input  logic [23:0]           bg_color,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic                  vs_out,
    output logic                  hs_out,
    output logic                  de_out,
    output logic [23:0]           rgb_out
);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [CW:0] DX_LIM = (CW+1)'(DATA_WIDTH);
    localparam logic [CW:0] DY_LIM = (CW+1)'(BMP_H);

    logic                  vs_act;
    logic                  vs_act_prev_reg;
    logic                  de_prev_reg;
    logic                  frame_start;
    logic [CW-1:0]         x_cnt_reg;
    logic [CW-1:0]         y_cnt_reg;
    logic [CW-1:0]         pos_x_reg;
    logic [CW-1:0]         pos_y_reg;
    logic                  ovl_en_reg;
    logic [CW:0]           dx;
    logic [CW:0]           dy;
    logic                  hit;

    logic                  hit0_reg, hit1_reg;
    logic [IW-1:0]         idx0_reg, idx1_reg;
    logic [23:0]           rgb0_reg, rgb1_reg;
    logic [2:0]            sync0_reg, sync1_reg;   // {vs, hs, de}
    logic [DATA_WIDTH-1:0] row_rev;
    logic                  pix_bit;
    logic [23:0]           rgb_next;

    assign vs_act      = VS_POL ? vs_in : ~vs_in;
    assign frame_start = vs_act & ~vs_act_prev_reg;

    // One extra bit keeps "left of / above the window" negative rather than aliased in range.
    assign dx  = {1'b0, x_cnt_reg} - {1'b0, pos_x_reg};
    assign dy  = {1'b0, y_cnt_reg} - {1'b0, pos_y_reg};
    assign hit = ovl_en_reg & de_in & (dx < DX_LIM) & (dy < DY_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_act_prev_reg <= 1'b0;
            de_prev_reg     <= 1'b0;
            x_cnt_reg       <= '0;
            y_cnt_reg       <= '0;
            pos_x_reg       <= '0;
            pos_y_reg       <= '0;
            ovl_en_reg      <= 1'b0;
        end else begin
            vs_act_prev_reg <= vs_act;
            de_prev_reg     <= de_in;
            if (!de_in)
                x_cnt_reg <= '0;
            else if (x_cnt_reg != '1)
                x_cnt_reg <= x_cnt_reg + 1'b1;
            if (frame_start) begin
                y_cnt_reg  <= '0;
                pos_x_reg  <= pos_x;
                pos_y_reg  <= pos_y;
                ovl_en_reg <= ovl_en;
            end else if (de_prev_reg && !de_in && y_cnt_reg != '1) begin
                y_cnt_reg <= y_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr  <= '0;
            hit0_reg  <= 1'b0;
            idx0_reg  <= '0;
            rgb0_reg  <= '0;
            sync0_reg <= '0;
            hit1_reg  <= 1'b0;
            idx1_reg  <= '0;
            rgb1_reg  <= '0;
            sync1_reg <= '0;
            vs_out    <= 1'b0;
            hs_out    <= 1'b0;
            de_out    <= 1'b0;
            rgb_out   <= '0;
        end else begin
            if (hit)
                rom_addr <= dy[ADDR_WIDTH-1:0];
            hit0_reg  <= hit;
            idx0_reg  <= dx[IW-1:0];
            rgb0_reg  <= rgb_in;
            sync0_reg <= {vs_in, hs_in, de_in};
            hit1_reg  <= hit0_reg;
            idx1_reg  <= idx0_reg;
            rgb1_reg  <= rgb0_reg;
            sync1_reg <= sync0_reg;
            vs_out    <= sync1_reg[2];
            hs_out    <= sync1_reg[1];
            de_out    <= sync1_reg[0];
            rgb_out   <= rgb_next;
        end
    end

    // Leftmost pixel lives in the MSB; reversing lets the column offset index directly.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rev
        assign row_rev[gi] = rom_rd_data[DATA_WIDTH-1-gi];
    end
    assign pix_bit = row_rev[idx1_reg];

`ifdef XH_OVERLAY_BG_EN
    always_comb begin
        rgb_next = rgb1_reg;
        if (hit1_reg)
            rgb_next = pix_bit ? fg_color : bg_color;
        if (!sync1_reg[0])
            rgb_next = '0;
    end
`else
    logic unused_bg;
    assign unused_bg = ^bg_color;

    always_comb begin
        rgb_next = rgb1_reg;
        if (hit1_reg && pix_bit)
            rgb_next = fg_color;
        if (!sync1_reg[0])
            rgb_next = '0;
    end
`endif

endmodule
